tick_scheduler: RTL and testbench
=================================

# tick_scheduler

- Shared timebase controller for the 100 MHz system clock.
- Runs one prescaler and derives NCH independently programmable clock-enable tick streams from it. Examples: 7-segment scan, 1 Hz seconds, game-step rate.
- Each channel's rate and enable are configured at runtime through a valid/ready port, so consumers use single-cycle enables in the `clk` domain instead of separate divided clocks.

## Interface
- PRESCALE, 100000: `clk` cycles per base tick (1 kHz at 100 MHz); legal range ≥ 2.
- NCH, 4: number of tick channels.
- DIV_W, 16: width of the per-channel divide value.
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  block can accept a configuration.
- cfg_ch  in  $clog2(NCH)  channel to configure.
- cfg_div  in  DIV_W  divide ratio in base ticks.
- cfg_en  in  1  channel enable.
- cfg_err  out  1  one-cycle pulse when a request is rejected.
- resync  in  1  one-cycle pulse that realigns all counters.
- base_tick  out  1  one-cycle pulse every PRESCALE cycles.
- tick  out  NCH  per-channel one-cycle pulses.
- ch_en  out  NCH  current enable state of each channel.

## Operation
- Reset values:
  - prescaler count, all channel counts, div = 0.
  - ch_en, tick, base_tick, cfg_err = 0; cfg_ready = 1.
  - The config FSM is in CFG_IDLE.
- Prescaler:
  - Counts 0..PRESCALE-1, then wraps to 0.
  - Register width is $clog2(PRESCALE).
  - base_tick is registered: it is high in the cycle after the count equals PRESCALE-1.
- Channel i, evaluated in a cycle where base_tick = 1 and ch_en[i] = 1:
  - If count == div-1: tick[i] is registered high for the next cycle and count returns to 0.
  - Otherwise count increments.
  - Tick period is div × PRESCALE cycles. div = 1 gives one tick per base_tick.
- A disabled channel holds its count and never pulses tick.
- Config FSM states:
  - CFG_IDLE: cfg_ready = 1. When cfg_valid is high, latch cfg_ch, cfg_div and cfg_en, then go to CFG_APPLY.
  - CFG_APPLY: cfg_ready = 0. Write div and ch_en for the latched channel and clear that channel's count, then return to CFG_IDLE.
- Rejection:
  - Request with cfg_en = 1 and cfg_div = 0 is rejected.
  - The channel is written with ch_en = 0, div unchanged, count cleared.
  - cfg_err pulses in the CFG_APPLY cycle.
- Request with cfg_en = 0: div is stored and the channel is disabled. No error.
- resync:
  - Clears the prescaler and all channel counts. base_tick and tick are forced low for the following cycle.
  - Enables and divs are untouched.
  - The next base_tick occurs PRESCALE+1 cycles after the resync cycle.
- Priorities:
  - CFG_APPLY on channel i in the same cycle as an advancing base_tick: the config write wins. Channel i neither counts nor ticks; other channels advance normally.
  - resync in the same cycle as CFG_APPLY: both take effect. The channel gets the new config with count 0.
  - resync takes priority over the prescaler wrap.
- Arithmetic: unsigned. Channel counts are DIV_W wide, and count never exceeds div-1.
- Changing div below the current count cannot occur, because every write clears count.

## Timing
- Config latency:
  - Request accepted on edge T; new settings are effective from T+1 (the CFG_APPLY cycle).
  - cfg_ready is high again at T+2.
  - Maximum throughput: one request per 2 cycles.
- Tick latency:
  - tick[i] is asserted 1 cycle after the base_tick that completes the period.
  - The first tick after enable is div base ticks later.
- cfg_ready does not depend combinationally on cfg_valid.
- All outputs are registered.
- Reset asserted mid-operation clears everything immediately. After reset release, the first base_tick occurs PRESCALE cycles later.

## Structure
- Package tick_pkg holds:
  - cfg state enum {CFG_IDLE, CFG_APPLY};
  - NCH_DEFAULT, DIV_W_DEFAULT and PRESCALE_DEFAULT constants.
- Sub-module tick_channel, instantiated NCH times from a generate loop. It contains the count, div and en registers, write port, clear input, advance input and tick output.
- The top level contains the prescaler, config FSM, error logic and resync fan-out.

## Test plan
- Reset then idle, PRESCALE = 4: base_tick pulses at cycles 4, 8, 12 after release. tick = 0 and ch_en = 0 throughout.
- Config ch 1, div = 3, en = 1: cfg_ready low exactly one cycle. tick[1] pulses every 12 cycles, each one cycle after a base_tick; the first pulse is 3 base ticks after apply.
- Config ch 2, div = 0, en = 1: cfg_err pulses once, ch_en[2] = 0, no tick[2]. A following valid request on ch 2 is accepted normally.
- Reconfigure ch 1 to div = 1 in the same cycle as a base_tick: ch 1 does not tick that period; ch 0 (div = 2, running) ticks on schedule. ch 1 then ticks on every base_tick.
- resync mid-period with ch 0 at count 1 (div 2): no pulses for PRESCALE+1 cycles. ch 0's first tick follows the second base_tick after resync.
- reset asserted while in CFG_APPLY with ticks running: all outputs 0 immediately, cfg_ready = 1, and previous config is lost (ch_en = 0 after release).

Source files
------------

// File: rtl/tick_pkg.sv
// Shared types and default sizing for the tick scheduler.
// Latency: n/a (types only).  Backpressure: n/a.
package tick_pkg;

    typedef enum logic {
        CFG_IDLE  = 1'b0,
        CFG_APPLY = 1'b1
    } cfg_state_t;

    localparam int NCH_DEFAULT      = 4;
    localparam int DIV_W_DEFAULT    = 16;
    localparam int PRESCALE_DEFAULT = 100000;

endpackage

// File: rtl/tick_channel.sv
// One divided tick stream: counts base ticks and pulses once every div of them.
// Latency: tick is registered, one cycle after the completing base tick.  Backpressure: none, write port always accepted.
module tick_channel #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_vld,
    input  logic             wr_div_upd,
    input  logic [DIV_W-1:0] wr_div,
    input  logic             wr_en,
    input  logic             clr,
    input  logic             adv,
    output logic             tick,
    output logic             en
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div;
    logic             at_end;

    assign at_end = (cnt == div - DIV_W'(1));

    // A config write beats both resync and advance; every write restarts the period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            div  <= '0;
            en   <= 1'b0;
            tick <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (wr_vld) begin
                cnt <= '0;
                en  <= wr_en;
                if (wr_div_upd) begin
                    div <= wr_div;
                end
            end else if (clr) begin
                cnt <= '0;
            end else if (adv && en) begin
                if (at_end) begin
                    cnt  <= '0;
                    tick <= 1'b1;
                end else begin
                    cnt <= cnt + DIV_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/tick_scheduler.sv
// Prescaler plus NCH programmable clock-enable tick channels, configured over a valid/ready port.
// Latency: config effective one cycle after acceptance; ticks one cycle after base_tick.  Backpressure: cfg_ready low for the single apply cycle.
module tick_scheduler
    import tick_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_DEFAULT,
    parameter int NCH      = NCH_DEFAULT,
    parameter int DIV_W    = DIV_W_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [$clog2(NCH)-1:0]  cfg_ch,
    input  logic [DIV_W-1:0]        cfg_div,
    input  logic                    cfg_en,
    output logic                    cfg_err,
    input  logic                    resync,
    output logic                    base_tick,
    output logic [NCH-1:0]          tick,
    output logic [NCH-1:0]          ch_en
);

    localparam int CH_W = $clog2(NCH);
    localparam int PS_W = $clog2(PRESCALE);

    logic [PS_W-1:0]  psc_cnt;
    logic             psc_wrap;

    cfg_state_t       state_q;
    cfg_state_t       state_d;
    logic             cfg_acc;
    logic             cfg_rej;
    logic [CH_W-1:0]  lat_ch;
    logic [DIV_W-1:0] lat_div;
    logic             lat_en;
    logic             lat_rej;

    assign psc_wrap = (psc_cnt == PS_W'(PRESCALE - 1));

    // resync outranks the wrap so the realigned period starts cleanly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            psc_cnt   <= '0;
            base_tick <= 1'b0;
        end else if (resync) begin
            psc_cnt   <= '0;
            base_tick <= 1'b0;
        end else if (psc_wrap) begin
            psc_cnt   <= '0;
            base_tick <= 1'b1;
        end else begin
            psc_cnt   <= psc_cnt + PS_W'(1);
            base_tick <= 1'b0;
        end
    end

    assign cfg_ready = (state_q == CFG_IDLE);
    assign cfg_acc   = cfg_ready && cfg_valid;
    assign cfg_rej   = cfg_en && (cfg_div == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= CFG_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            CFG_IDLE:  if (cfg_valid) state_d = CFG_APPLY;
            CFG_APPLY: state_d = CFG_IDLE;
            default:   state_d = CFG_IDLE;
        endcase
    end

    // The error flag is raised at acceptance so it is visible during the apply cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_ch  <= '0;
            lat_div <= '0;
            lat_en  <= 1'b0;
            lat_rej <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_acc && cfg_rej;
            if (cfg_acc) begin
                lat_ch  <= cfg_ch;
                lat_div <= cfg_div;
                lat_en  <= cfg_en;
                lat_rej <= cfg_rej;
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic wr_sel;

        assign wr_sel = (state_q == CFG_APPLY) && (lat_ch == CH_W'(g));

        tick_channel #(
            .DIV_W (DIV_W)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .wr_vld     (wr_sel),
            .wr_div_upd (!lat_rej),
            .wr_div     (lat_div),
            .wr_en      (lat_en && !lat_rej),
            .clr        (resync),
            .adv        (base_tick),
            .tick       (tick[g]),
            .en         (ch_en[g])
        );
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// Randomized scoreboard bench for tick_scheduler with a timeline-level reference model.
module tb_tick_scheduler;

    localparam int P     = 4;
    localparam int NCH   = 4;
    localparam int DIV_W = 16;
    localparam int CH_W  = $clog2(NCH);

    typedef struct packed {
        logic           bt;
        logic [NCH-1:0] tk;
        logic [NCH-1:0] en;
        logic           rdy;
        logic           err;
    } exp_t;

    logic             clk;
    logic             reset;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_en;
    logic             cfg_err;
    logic             resync;
    logic             base_tick;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   ch_en;

    int tests = 0;
    int fails = 0;
    exp_t exp_q[$];

    tick_scheduler #(
        .PRESCALE (P),
        .NCH      (NCH),
        .DIV_W    (DIV_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_en    (cfg_en),
        .cfg_err   (cfg_err),
        .resync    (resync),
        .base_tick (base_tick),
        .tick      (tick),
        .ch_en     (ch_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: elapsed cycles since the timing origin and base ticks consumed per channel.
    initial begin : model
        int   elapsed;
        bit   pend;
        int   l_ch, l_div;
        bit   l_en;
        bit   m_en [NCH];
        int   m_div[NCH];
        int   m_n  [NCH];
        bit   e_bt, e_err, nb_bt, nb_err;
        logic [NCH-1:0] e_tick, nb_tick, en_vec;
        elapsed = 0; pend = 0; l_ch = 0; l_div = 0; l_en = 0;
        e_bt = 0; e_err = 0; e_tick = '0;
        for (int i = 0; i < NCH; i++) begin m_en[i] = 0; m_div[i] = 0; m_n[i] = 0; end
        forever begin
            @(posedge clk);
            if (!reset) begin
                elapsed = 0; pend = 0;
                e_bt = 0; e_err = 0; e_tick = '0;
                for (int i = 0; i < NCH; i++) begin m_en[i] = 0; m_div[i] = 0; m_n[i] = 0; end
            end else begin
                nb_tick = '0;
                for (int i = 0; i < NCH; i++) begin
                    if (e_bt && m_en[i] && !(pend && l_ch == i) && !resync) begin
                        m_n[i]++;
                        if (m_n[i] % m_div[i] == 0) nb_tick[i] = 1'b1;
                    end
                end
                if (resync) begin
                    elapsed = 0;
                    nb_bt = 0;
                    nb_tick = '0;
                    for (int i = 0; i < NCH; i++) m_n[i] = 0;
                end else begin
                    elapsed++;
                    nb_bt = (elapsed % P == 0);
                end
                nb_err = 0;
                if (pend) begin
                    m_n[l_ch] = 0;
                    nb_tick[l_ch] = 1'b0;
                    if (l_en && l_div == 0) begin
                        m_en[l_ch] = 0;
                    end else begin
                        m_en[l_ch]  = l_en;
                        m_div[l_ch] = l_div;
                    end
                    pend = 0;
                end else if (cfg_valid) begin
                    l_ch  = int'(cfg_ch);
                    l_div = int'(cfg_div);
                    l_en  = cfg_en;
                    pend  = 1;
                    nb_err = cfg_en && (cfg_div == '0);
                end
                e_bt = nb_bt; e_tick = nb_tick; e_err = nb_err;
            end
            for (int i = 0; i < NCH; i++) en_vec[i] = m_en[i];
            exp_q.push_back('{bt: e_bt, tk: e_tick, en: en_vec, rdy: !pend, err: e_err});
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    // Monitor: every cycle's outputs are compared against the model's entry for that cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() == 0) begin
            if (reset) begin
                tests++; fails++;
                $display("FAIL scoreboard_underflow at %0t: got empty queue, expected an entry", $time);
            end
        end else begin
            e = exp_q.pop_front();
            if (!reset) e = '{bt: 1'b0, tk: '0, en: '0, rdy: 1'b1, err: 1'b0};
            chk("base_tick", 32'(base_tick), 32'(e.bt));
            chk("tick",      32'(tick),      32'(e.tk));
            chk("ch_en",     32'(ch_en),     32'(e.en));
            chk("cfg_ready", 32'(cfg_ready), 32'(e.rdy));
            chk("cfg_err",   32'(cfg_err),   32'(e.err));
        end
    end

    task automatic send_cfg(input int ch, input int dv, input bit en);
        int w;
        w = 0;
        @(negedge clk);
        while (!cfg_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        tests++;
        if (!cfg_ready) begin
            fails++;
            $display("FAIL cfg_ready_timeout at %0t: got ready=0, expected ready=1 within 10 cycles", $time);
        end
        cfg_valid = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_div   = DIV_W'(dv);
        cfg_en    = en;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic wait_bt();
        int w;
        w = 0;
        @(negedge clk);
        while (!base_tick && w < 2 * P + 2) begin
            @(negedge clk);
            w++;
        end
        tests++;
        if (!base_tick) begin
            fails++;
            $display("FAIL base_tick_timeout at %0t: got no base_tick, expected one within %0d cycles", $time, 2 * P + 2);
        end
    endtask

    task automatic do_resync();
        @(negedge clk);
        resync = 1'b1;
        @(posedge clk);
        #1;
        resync = 1'b0;
    endtask

    task automatic pulse_reset(input int n);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin : stim
        reset = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_en = 1'b0; resync = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (14) @(posedge clk);

        send_cfg(1, 3, 1'b1);
        repeat (30) @(posedge clk);

        send_cfg(2, 0, 1'b1);
        send_cfg(2, 2, 1'b0);
        repeat (10) @(posedge clk);

        send_cfg(0, 2, 1'b1);
        repeat (12) @(posedge clk);
        // Land the ch 1 apply cycle exactly on a base tick.
        wait_bt();
        repeat (P - 1) @(negedge clk);
        cfg_valid = 1'b1; cfg_ch = CH_W'(1); cfg_div = DIV_W'(1); cfg_en = 1'b1;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        repeat (20) @(posedge clk);

        wait_bt();
        repeat (2) @(negedge clk);
        do_resync();
        repeat (20) @(posedge clk);

        send_cfg(3, 1, 1'b1);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (12) @(posedge clk);

        for (int k = 0; k < 80; k++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 6)       send_cfg($urandom_range(0, NCH - 1), $urandom_range(0, 4), $urandom_range(0, 3) != 0);
            else if (r < 8)  do_resync();
            else if (r == 8) pulse_reset($urandom_range(1, 2));
            else             send_cfg($urandom_range(0, NCH - 1), $urandom_range(1, 3), 1'b1);
            repeat ($urandom_range(0, 12)) @(negedge clk);
        end

        repeat (5) @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
